// File: rtl/mux4_serial_driver.sv
// mux4_serial_driver
//   Parallel-to-serial driver sitting directly in front of a 4:1 mux.
//   A 4-bit word is taken over a valid/ready handshake and parked on the
//   mux data inputs. The 2-bit select then walks all four channels, each
//   held for HOLD cycles, so the mux output carries the word one bit at a
//   time. A new word may be accepted in the final hold cycle of the
//   current one, giving gap-free back-to-back streaming.
module mux4_serial_driver #(
    parameter int HOLD      = 1,     // cycles per bit on the select, >= 1
    parameter bit MSB_FIRST = 1'b0   // 0: select 0,1,2,3   1: select 3,2,1,0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] mux_i,
    output logic [1:0] mux_s,
    output logic       bit_valid,
    output logic       bit_last,
    output logic       busy
);

    // hold_cnt needs clog2(HOLD) bits, but never fewer than one.
    localparam int                HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [1:0]        FIRST_SEL = MSB_FIRST ? 2'd3 : 2'd0;
    localparam logic [1:0]        LAST_BIT  = 2'd3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic [1:0]        bit_cnt;
    logic [1:0]        bit_cnt_nxt;
    logic [3:0]        mux_i_nxt;
    logic [1:0]        mux_s_nxt;

    logic hold_end;   // last cycle of the current bit
    logic word_end;   // last cycle of the last bit of the word
    logic accept;     // handshake completes on the coming edge

    // Handshake and status decode from the registered state. in_ready is
    // gated by rst so nothing is offered while the block is held in reset;
    // the other outputs already follow the asynchronously cleared state.
    always_comb begin
        hold_end  = (hold_cnt == HOLD_LAST);
        word_end  = (state == SHIFT) && (bit_cnt == LAST_BIT) && hold_end;
        in_ready  = !rst && ((state == IDLE) || word_end);
        accept    = in_valid && in_ready;
        bit_valid = (state == SHIFT);
        busy      = (state == SHIFT);
        bit_last  = (state == SHIFT) && (bit_cnt == LAST_BIT);
    end

    // Next-state logic: load on accept, otherwise step the select through
    // the word. The select is never advanced past the final channel, so it
    // stays parked there once the word ends and no new word follows.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        bit_cnt_nxt  = bit_cnt;
        mux_i_nxt    = mux_i;
        mux_s_nxt    = mux_s;

        if (accept) begin
            // Covers both a load from IDLE and a back-to-back load in the
            // final hold cycle of the previous word.
            state_nxt    = SHIFT;
            hold_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            mux_i_nxt    = in_data;
            mux_s_nxt    = FIRST_SEL;
        end else if (state == SHIFT) begin
            if (!hold_end) begin
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end else if (bit_cnt == LAST_BIT) begin
                // Word finished with nothing queued: go idle, keep the
                // word and select where they are.
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
            end else begin
                hold_cnt_nxt = '0;
                bit_cnt_nxt  = bit_cnt + 2'd1;
                mux_s_nxt    = MSB_FIRST ? (mux_s - 2'd1) : (mux_s + 2'd1);
            end
        end
    end

    // State and datapath registers; an asserted rst aborts any word in
    // progress immediately and nothing of it is resumed afterwards.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments
        // so every register samples the pre-edge values of the others.
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            bit_cnt  <= '0;
            mux_i    <= 4'b0;
            mux_s    <= FIRST_SEL;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            mux_i    <= mux_i_nxt;
            mux_s    <= mux_s_nxt;
        end
    end

endmodule

// File: tb/tb_mux4_serial_driver.sv
// tb_mux4_serial_driver
//   Two instances with different timing/order settings share clock and
//   reset. Expected serial behaviour is derived per cycle from the word,
//   the cycle offset within the word and the instance parameters.
module tb_mux4_serial_driver;

    localparam int HOLD_A = 1;
    localparam bit MSB_A  = 1'b0;
    localparam int HOLD_B = 3;
    localparam bit MSB_B  = 1'b1;

    logic       clk;
    logic       rst;

    logic [3:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] a_mux_i;
    logic [1:0] a_mux_s;
    logic       a_bit_valid;
    logic       a_bit_last;
    logic       a_busy;

    logic [3:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] b_mux_i;
    logic [1:0] b_mux_s;
    logic       b_bit_valid;
    logic       b_bit_last;
    logic       b_busy;

    int tests_run = 0;
    int tests_failed = 0;

    mux4_serial_driver #(.HOLD(HOLD_A), .MSB_FIRST(MSB_A)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_data),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .mux_i     (a_mux_i),
        .mux_s     (a_mux_s),
        .bit_valid (a_bit_valid),
        .bit_last  (a_bit_last),
        .busy      (a_busy)
    );

    mux4_serial_driver #(.HOLD(HOLD_B), .MSB_FIRST(MSB_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_data),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .mux_i     (b_mux_i),
        .mux_s     (b_mux_s),
        .bit_valid (b_bit_valid),
        .bit_last  (b_bit_last),
        .busy      (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: the directed sequence is a fixed number of cycles.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of sequence, required finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hold_of(input int d);
        return (d == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic bit msb_of(input int d);
        return (d == 0) ? MSB_A : MSB_B;
    endfunction

    task automatic drive(input int d, input logic v, input logic [3:0] data);
        if (d == 0) begin
            a_valid = v;
            a_data  = data;
        end else begin
            b_valid = v;
            b_data  = data;
        end
    endtask

    task automatic drive_valid(input int d, input logic v);
        if (d == 0) a_valid = v;
        else        b_valid = v;
    endtask

    task automatic peek(input int d, output logic r, output logic v, output logic l,
                        output logic b, output logic [3:0] i, output logic [1:0] s);
        if (d == 0) begin
            r = a_ready; v = a_bit_valid; l = a_bit_last; b = a_busy; i = a_mux_i; s = a_mux_s;
        end else begin
            r = b_ready; v = b_bit_valid; l = b_bit_last; b = b_busy; i = b_mux_i; s = b_mux_s;
        end
    endtask

    // Outputs while rst is asserted.
    task automatic reset_check(input int d, input string tag);
        logic r, v, l, b;
        logic [3:0] i;
        logic [1:0] s;
        peek(d, r, v, l, b, i, s);
        check({tag, ".in_ready"},  8'(r), 8'(0));
        check({tag, ".bit_valid"}, 8'(v), 8'(0));
        check({tag, ".bit_last"},  8'(l), 8'(0));
        check({tag, ".busy"},      8'(b), 8'(0));
        check({tag, ".mux_i"},     8'(i), 8'(0));
        check({tag, ".mux_s"},     8'(s), msb_of(d) ? 8'(3) : 8'(0));
    endtask

    // Outputs in IDLE with the given parked word and select.
    task automatic idle_check(input int d, input string tag,
                              input logic [3:0] w, input logic [1:0] sel);
        logic r, v, l, b;
        logic [3:0] i;
        logic [1:0] s;
        peek(d, r, v, l, b, i, s);
        check({tag, ".in_ready"},  8'(r), 8'(1));
        check({tag, ".bit_valid"}, 8'(v), 8'(0));
        check({tag, ".busy"},      8'(b), 8'(0));
        check({tag, ".mux_i"},     8'(i), 8'(w));
        check({tag, ".mux_s"},     8'(s), 8'(sel));
    endtask

    // Caller has presented word w with valid high before the accepting
    // edge. Checks every cycle of the word. Optionally pokes a stray word
    // (4'hF) at cycle 'poke' and optionally chains next_w at the last cycle.
    task automatic check_word(input int d, input string tag, input logic [3:0] w,
                              input bit chain, input logic [3:0] next_w, input int poke);
        int h;
        int cycles;
        int k;
        int idx;
        logic r, v, l, b;
        logic [3:0] i;
        logic [1:0] s;
        h = hold_of(d);
        cycles = 4 * h;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            k   = c / h;
            idx = msb_of(d) ? (3 - k) : k;
            peek(d, r, v, l, b, i, s);
            check({tag, ".bit_valid"}, 8'(v), 8'(1));
            check({tag, ".busy"},      8'(b), 8'(1));
            check({tag, ".mux_i"},     8'(i), 8'(w));
            check({tag, ".mux_s"},     8'(s), 8'(idx));
            check({tag, ".serial"},    8'(i[s]), 8'(w[idx]));
            check({tag, ".bit_last"},  8'(l), 8'(k == 3));
            check({tag, ".in_ready"},  8'(r), 8'(c == cycles - 1));
            if (c == 0)        drive_valid(d, 1'b0);
            if (c == poke)     drive(d, 1'b1, 4'hF);
            if (c == poke + 1) drive_valid(d, 1'b0);
            if (c == cycles - 1) begin
                if (chain) drive(d, 1'b1, next_w);
                else       drive_valid(d, 1'b0);
            end
        end
        if (!chain) begin
            @(negedge clk);
            idle_check(d, {tag, ".end"}, w, msb_of(d) ? 2'd0 : 2'd3);
        end
    endtask

    initial begin
        logic [3:0] w;
        logic [3:0] nw;
        bit         chain;
        int         d;
        int         poke;

        rst     = 1'b1;
        a_valid = 1'b0;
        a_data  = 4'h0;
        b_valid = 1'b0;
        b_data  = 4'h0;

        // Power-on reset values.
        #1;
        reset_check(0, "por_a");
        reset_check(1, "por_b");

        @(negedge clk);
        rst = 1'b0;
        #1;
        idle_check(0, "rel_a", 4'h0, 2'd0);
        idle_check(1, "rel_b", 4'h0, 2'd3);

        // Single word, HOLD=1, LSB first: bits 1,1,0,1.
        drive(0, 1'b1, 4'b1011);
        check_word(0, "w1011", 4'b1011, 1'b0, 4'h0, -1);

        // MSB first, HOLD=3: bits 0,1,1,0 over 12 cycles.
        drive(1, 1'b1, 4'b0110);
        check_word(1, "w0110", 4'b0110, 1'b0, 4'h0, -1);

        // Back-to-back A then 5 with valid held: 8 contiguous bits.
        drive(0, 1'b1, 4'hA);
        check_word(0, "b2b_A", 4'hA, 1'b1, 4'h5, -1);
        check_word(0, "b2b_5", 4'h5, 1'b0, 4'h0, -1);

        // Stray valid pulse during bit 2 is ignored.
        drive(0, 1'b1, 4'h0);
        check_word(0, "ign_a", 4'h0, 1'b0, 4'h0, 1);
        drive(1, 1'b1, 4'h0);
        check_word(1, "ign_b", 4'h0, 1'b0, 4'h0, 4);

        // Reset during bit 1 of 4'hC with valid still high.
        drive(0, 1'b1, 4'hC);
        @(negedge clk);
        drive(0, 1'b1, 4'hC);
        rst = 1'b1;
        #1;
        reset_check(0, "mid_rst_a");
        reset_check(1, "mid_rst_b");
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 4'h0);
        #1;
        idle_check(0, "post_rst_a", 4'h0, 2'd0);
        drive(0, 1'b1, 4'h3);
        check_word(0, "w3", 4'h3, 1'b0, 4'h0, -1);

        // Randomised words, chains and stray pulses on both instances.
        for (int n = 0; n < 14; n++) begin
            d = int'($urandom_range(0, 1));
            w = 4'($urandom);
            drive(d, 1'b1, w);
            for (int m = 0; m < 3; m++) begin
                chain = (m < 2) && ($urandom_range(0, 1) == 1);
                nw    = 4'($urandom);
                poke  = ($urandom_range(0, 1) == 1)
                        ? int'($urandom_range(1, 4 * hold_of(d) - 2)) : -1;
                check_word(d, "rnd", w, chain, nw, poke);
                if (!chain) break;
                w = nw;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
